// File: rtl/mul_seq_pkg.sv
// Shared definitions for the shift-add multiplier: word width, FSM encodings, counter sizing.
// No logic, no latency, no backpressure.
// Early-exit build option: MUL_EARLY_EXIT_EN (consumed by mul_seq).
`ifndef WORD
`define WORD 64
`endif

package mul_seq_pkg;

    localparam int WORD = `WORD;

    // 2'd3 is never entered; the FSM decodes it back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Bundles the multiplier request/result signals and the shared-adder port pair.
// Pure wiring, zero latency; start is only honoured while the multiplier is not busy.
import mul_seq_pkg::*;

interface mul_seq_if #(
    parameter int WIDTH = WORD
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;

    // master: parent datapath (issues requests, owns the adder); slave: mul_seq.
    modport master (
        output start, multiplicand, multiplier, add_sum,
        input  add_a, add_b, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier, add_sum,
        output add_a, add_b, busy, done, product
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier controller driving an external shared adder (MUL, low WIDTH bits).
// Latency: WIDTH busy cycles then one done cycle (fewer busy cycles with MUL_EARLY_EXIT_EN).
// Backpressure: start is ignored while busy; no request queueing.
import mul_seq_pkg::*;

module mul_seq #(
    parameter int WIDTH = WORD,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic     clk,
    input  logic     reset_n,
    mul_seq_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic             done_q;
    logic             last_iter;

`ifdef MUL_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain beyond the one being consumed now.
    assign last_iter = (count == CNT_W'(WIDTH - 1)) || ((r_q >> 1) == '0);
`else
    assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            p_q    <= '0;
            m_q    <= '0;
            r_q    <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= S_BUSY;
                        busy_q <= 1'b1;
                        p_q    <= '0;
                        m_q    <= bus.multiplicand;
                        r_q    <= bus.multiplier;
                        count  <= '0;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    p_q   <= bus.add_sum;
                    m_q   <= m_q << 1;
                    r_q   <= r_q >> 1;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Adder operands come from registers only, and are parked at zero when the adder is not ours.
    assign bus.add_a   = busy_q ? p_q : '0;
    assign bus.add_b   = (busy_q && r_q[0]) ? m_q : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural adder and a product/latency reference model.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_mul_seq;
    import mul_seq_pkg::*;

    localparam int W = 64;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    mul_seq_if #(.WIDTH(W)) bus ();

    mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // The shared adder owned by the parent: combinational, carry dropped.
    assign bus.add_sum = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * b;
    endfunction

    function automatic int ref_busy_cycles(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return msb + 1;
`else
        return (b == b) ? W : W;
`endif
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Issue one operation from IDLE and follow it to its done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int nbusy, output logic dseen,
                          output logic [W-1:0] p, output logic dafter);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
        @(negedge clk);
        bus.start = 1'b0; bus.multiplicand = rand64(); bus.multiplier = rand64();
        nbusy = 0;
        while (bus.busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
        dseen = bus.done;
        p     = bus.product;
        @(negedge clk);
        dafter = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags busy/done=%b required 00", {bus.busy, bus.done});
        end
        n_cmp++;
        if (bus.product !== '0) begin
            n_err++; $display("FAIL reset_product got %h required 0", bus.product);
        end
        n_cmp++;
        if ({bus.add_a, bus.add_b} !== '0) begin
            n_err++; $display("FAIL reset_adder add_a=%h add_b=%h required 0", bus.add_a, bus.add_b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int nb; logic ds, da; logic [W-1:0] p;
        run_op(a, b, nb, ds, p, da);
        n_cmp++;
        if (nb !== ref_busy_cycles(b)) begin
            n_err++; $display("FAIL %s_busy_cycles got %0d required %0d", name, nb, ref_busy_cycles(b));
        end
        n_cmp++;
        if (ds !== 1'b1) begin
            n_err++; $display("FAIL %s_done got %b required 1", name, ds);
        end
        n_cmp++;
        if (p !== ref_product(a, b)) begin
            n_err++; $display("FAIL %s_product got %h required %h", name, p, ref_product(a, b));
        end
        n_cmp++;
        if (da !== 1'b0) begin
            n_err++; $display("FAIL %s_done_width done still %b one cycle later, required 0", name, da);
        end
        n_cmp++;
        if (bus.product !== ref_product(a, b)) begin
            n_err++; $display("FAIL %s_product_hold got %h required %h", name, bus.product, ref_product(a, b));
        end
    endtask

    task automatic test_ignore_start();
        int nb;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 64'd7; bus.multiplier = 64'd6;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            if (nb == 20) begin
                bus.start = 1'b1; bus.multiplicand = 64'd9; bus.multiplier = 64'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_cmp++;
        if (nb !== W) begin
            n_err++; $display("FAIL ignore_busy_cycles got %0d required %0d", nb, W);
        end
        n_cmp++;
        if ({bus.done, bus.product} !== {1'b1, 64'd42}) begin
            n_err++; $display("FAIL ignore_result done=%b product=%h required done=1 product=2a", bus.done, bus.product);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++; $display("FAIL ignore_to_idle busy/done=%b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_reset_mid();
        int nb; logic seen;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 64'hFFFF; bus.multiplier = 64'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 1;
        while (bus.busy && nb < 10) begin
            nb++;
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.product} !== {2'b00, 64'd0}) begin
            n_err++; $display("FAIL reset_mid busy=%b done=%b product=%h required 0 0 0", bus.busy, bus.done, bus.product);
        end
        n_cmp++;
        if ({bus.add_a, bus.add_b} !== '0) begin
            n_err++; $display("FAIL reset_mid_adder add_a=%h add_b=%h required 0", bus.add_a, bus.add_b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_abort activity after reset got %b required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 64'd2; bus.multiplier = 64'd3;
        @(negedge clk);
        bus.multiplicand = 64'd6; bus.multiplier = 64'd6;
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.done, bus.product} !== {1'b1, 64'd6}) begin
            n_err++; $display("FAIL b2b_first done=%b product=%h required done=1 product=6", bus.done, bus.product);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.product} !== {1'b1, 64'd0}) begin
            n_err++; $display("FAIL b2b_reaccept busy=%b product=%h required busy=1 product=0", bus.busy, bus.product);
        end
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        n_cmp++;
        if ({nb, bus.done, bus.product} !== {W, 1'b1, 64'd36}) begin
            n_err++; $display("FAIL b2b_second cycles=%0d done=%b product=%h required %0d 1 24", nb, bus.done, bus.product, W);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = rand64();
            b = rand64();
            if (i == 1) b = b >> $urandom_range(60, 1);
            if (i == 2) a = -a;
            test_basic(a, b, "rand");
        end
    endtask

`ifdef MUL_EARLY_EXIT_EN
    task automatic test_early_exit();
        test_basic(64'd4, 64'd5, "early_4x5");
        test_basic(64'd4, 64'd0, "early_x0");
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic(64'd3, 64'd5, "mul_3x5");
        test_basic(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "wrap");
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef MUL_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
